serial_pkt_router: RTL and testbench
====================================

// Module: serial_pkt_router
// PURPOSE
//  Parametrised successor to the single-channel serial detect/count/transmit device.
//  Hunts a serial bitstream for a programmable header, then reads an address field and a length field.
//  Forwards the following payload bits to one of NCH output lanes with per-lane valid.
//  Sits between a serial link input and downstream per-channel serial consumers.
// PARAMETERS
//  HDR_W    4        header length in bits
//  HDR_PAT  4'b1101  header pattern, MSB received first
//  ADDR_W   2        address field width; NCH = 2**ADDR_W lanes
//  LEN_W    4        length field width; payload length L = 0..2**LEN_W-1 bits
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       reset, asynchronous, active-low (0 = reset)
//  in        in   1       serial data, sampled every rising edge
//  out       out  NCH     out[c] = in when lane c is forwarding, else 0 (combinational from in)
//  outvalid  out  NCH     one-hot; bit c high while lane c forwards a payload bit
//  busy      out  1       high in any state other than HUNT
//  done      out  1       1-cycle registered pulse at packet completion
//  perr      out  1       1-cycle parity-error pulse (see CONFIGURATION); 0 when feature absent
// BEHAVIOUR
//  Reset: state=HUNT; shift reg, fill count, addr, len and counters cleared; outvalid=0, out=0, busy=0, done=0, perr=0.
//  Reset mid-packet aborts the packet immediately (async); no done is issued.
//  FSM: HUNT -> ADDR -> LEN -> PAYLOAD -> (PARITY) -> HUNT. All fields are MSB first.
//  HUNT: shift in each bit; fill counter saturates at HDR_W.
//    Match when fill==HDR_W and shreg==HDR_PAT, evaluated on the newly shifted value.
//    Overlapping matches are allowed within HUNT. On match, go to ADDR at that edge.
//    Shreg and fill are cleared on every entry to HUNT, so no header straddles packets.
//  ADDR: capture ADDR_W bits over ADDR_W edges, then go to LEN.
//  LEN: capture LEN_W bits. After the last LEN bit:
//    L>0 -> PAYLOAD with remaining count = L.
//    L==0 -> HUNT with done=1 next cycle; no outvalid is asserted.
//  PAYLOAD: outvalid[addr]=1 and out[addr]=in combinationally (zero latency); all other lanes 0.
//    Decrement at each edge; after the L-th payload edge go to HUNT (or PARITY); done pulses the following cycle.
//  Payload bits are never examined for headers.
//  Widths: counter is LEN_W bits and is never wrapped; L = 2**LEN_W-1 is a legal maximum.
//  Exactly L outvalid cycles occur per packet. Back-to-back packets: HUNT resumes the cycle after the last payload/parity bit.
// CONFIGURATION
//  Macro SERIAL_PKT_ROUTER_PARITY_EN.
//  Defined:
//    After PAYLOAD (or after LEN when L==0), one PARITY cycle samples an even-parity bit over the payload bits.
//    outvalid stays 0 in PARITY.
//    On mismatch, perr pulses with done (same cycle). done is delayed by the PARITY cycle.
//  Undefined: no PARITY state, perr tied 0, timing as in BEHAVIOUR.
// STRUCTURE
//  Header serial_pkt_router_defs.vh: state encodings (HUNT, ADDR, LEN, PAYLOAD, PARITY) and default field widths.
//  Sub-module hdr_detector (HDR_W, HDR_PAT): shift reg + fill count, inputs clr and in, output match.
//  Top level holds FSM, field capture, payload counter and lane decode.
// TESTING
//  Header 1101, addr 10, len 0011, payload 101:
//    outvalid=4'b0100 for exactly 3 cycles; out[2] mirrors 1,0,1; done 1 cycle after; busy drops with HUNT.
//  Stream 1101101 (overlap) then addr 01, len 0001, bit 1:
//    Header matched at bit 4 (first match wins); the next bits 101 are taken as ADDR/LEN, not as a header.
//  Len 0000: no outvalid; done pulses 1 cycle after the last LEN bit; next header is accepted immediately.
//  Len 1111: 15 outvalid cycles, no counter wrap.
//    Follow immediately with a second header: the second packet is detected.
//  Assert rst low in PAYLOAD cycle 2: outvalid/out go 0 at once, no done; after release, HUNT finds the next header.
//  PARITY_EN, payload 110:
//    Parity bit 0 -> done, perr=0. Parity bit 1 -> done with perr=1. Without the macro, perr stays 0.

Source files
------------

// File: rtl/serial_pkt_router_pkg.sv
// Shared state encoding and default field geometry for serial_pkt_router.
// Optional parity stage is enabled with SERIAL_PKT_ROUTER_PARITY_EN.
package serial_pkt_router_pkg;

    localparam int              DEF_HDR_W   = 4;
    localparam logic [3:0]      DEF_HDR_PAT = 4'b1101;
    localparam int              DEF_ADDR_W  = 2;
    localparam int              DEF_LEN_W   = 4;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_pkt_router_hdr_detector.sv
// Header hunter: MSB-first shift register with saturating fill count.
// match is evaluated on the value that will be shifted in at this edge.
module hdr_detector
    import serial_pkt_router_pkg::*;
#(
    parameter int              HDR_W   = DEF_HDR_W,
    parameter logic [HDR_W-1:0] HDR_PAT = DEF_HDR_PAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in,
    output logic match
);

    localparam int FILL_W = $clog2(HDR_W + 1);

    logic [HDR_W-1:0]  shreg_q, shreg_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        shreg_d = HDR_W'({shreg_q, in});
        fill_d  = (fill_q == FILL_W'(HDR_W)) ? fill_q : fill_q + FILL_W'(1);
        match   = (fill_d == FILL_W'(HDR_W)) && (shreg_d == HDR_PAT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else if (clr) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/serial_pkt_router.sv
// Serial packet router: header hunt, addr/len capture, payload forwarded to one lane.
// Define SERIAL_PKT_ROUTER_PARITY_EN to add a trailing even-parity check cycle.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  HUNT    | shifting stream looking for the header
//  ADDR    | capturing ADDR_W address bits
//  LEN     | capturing LEN_W length bits into the down-counter
//  PAYLOAD | forwarding bits to lane addr, counting down to 1
//  PARITY  | sampling the even-parity bit (parity build only)
module serial_pkt_router
    import serial_pkt_router_pkg::*;
#(
    parameter int               HDR_W   = DEF_HDR_W,
    parameter logic [HDR_W-1:0] HDR_PAT = DEF_HDR_PAT,
    parameter int               ADDR_W  = DEF_ADDR_W,
    parameter int               LEN_W   = DEF_LEN_W,
    localparam int              NCH     = 2 ** ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] outvalid,
    output logic           busy,
    output logic           done,
    output logic           perr
);

    localparam int FLD_W = $clog2(max_int(ADDR_W, LEN_W) + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_shift;
    logic [FLD_W-1:0]  fld_q, fld_d;
    logic              done_q, done_d;
    logic              hdr_clr;
    logic              hdr_match;
    logic [NCH-1:0]    lane_sel;
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    hdr_detector #(
        .HDR_W   (HDR_W),
        .HDR_PAT (HDR_PAT)
    ) u_hdr (
        .clk   (clk),
        .rst   (rst),
        .clr   (hdr_clr),
        .in    (in),
        .match (hdr_match)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        fld_d     = fld_q;
        done_d    = 1'b0;
        len_shift = LEN_W'({cnt_q, in});
        // detector holds cleared outside HUNT so a header never straddles packets
        hdr_clr   = (state_q != S_HUNT);
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_HUNT: begin
                if (hdr_match) begin
                    state_d = S_ADDR;
                    fld_d   = FLD_W'(ADDR_W - 1);
                    addr_d  = '0;
                    cnt_d   = '0;
                    hdr_clr = 1'b1;
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                addr_d = ADDR_W'({addr_q, in});
                if (fld_q == '0) begin
                    state_d = S_LEN;
                    fld_d   = FLD_W'(LEN_W - 1);
                end else begin
                    fld_d = fld_q - FLD_W'(1);
                end
            end
            S_LEN: begin
                cnt_d = len_shift;
                if (fld_q == '0) begin
                    if (len_shift == '0) begin
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_HUNT;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else begin
                    fld_d = fld_q - FLD_W'(1);
                end
            end
            S_PAYLOAD: begin
                cnt_d = cnt_q - LEN_W'(1);
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
                par_d = par_q ^ in;
`endif
                // terminal count: this edge consumes the last payload bit
                if (cnt_q == LEN_W'(1)) begin
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_HUNT;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
            S_PARITY: begin
                state_d = S_HUNT;
                done_d  = 1'b1;
                perr_d  = in ^ par_q;
            end
`endif
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HUNT;
            addr_q  <= '0;
            cnt_q   <= '0;
            fld_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            fld_q   <= fld_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_PKT_ROUTER_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    always_comb begin
        lane_sel         = '0;
        lane_sel[addr_q] = 1'b1;
    end

    assign outvalid = (state_q == S_PAYLOAD) ? lane_sel : '0;
    assign out      = outvalid & {NCH{in}};
    assign busy     = (state_q != S_HUNT);
    assign done     = done_q;

endmodule

// File: tb/tb_serial_pkt_router.sv
// Directed bench for serial_pkt_router; follows SERIAL_PKT_ROUTER_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_serial_pkt_router;

    logic       clk;
    logic       rst;
    logic       in_s;
    logic [3:0] out_s;
    logic [3:0] outvalid;
    logic       busy;
    logic       done;
    logic       perr;

    int n_cmp = 0;
    int n_bad = 0;

    serial_pkt_router dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_s),
        .out      (out_s),
        .outvalid (outvalid),
        .busy     (busy),
        .done     (done),
        .perr     (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one bit after the falling edge; outputs are sampled 1ns later
    task automatic drive(input logic b);
        @(negedge clk);
        in_s = b;
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(v[i]);
    endtask

    task automatic send_hdr(input logic [1:0] addr, input logic [3:0] len);
        send_bits(32'b1101, 4);
        send_bits({30'b0, addr}, 2);
        send_bits({28'b0, len}, 4);
    endtask

    task automatic pay_bit(input string tag, input logic b, input logic [3:0] lane);
        drive(b);
        chk({tag, "_ov"},  {28'b0, outvalid}, {28'b0, lane});
        chk({tag, "_out"}, {28'b0, out_s},    {28'b0, (b ? lane : 4'b0)});
    endtask

    // closes a packet: optional parity cycle, then the done cycle carrying bit nxt
    task automatic finish_pkt(input string tag, input logic par, input logic exp_perr, input logic nxt);
        logic e;
`ifdef SERIAL_PKT_ROUTER_PARITY_EN
        drive(par);
        chk({tag, "_par_ov"},   {28'b0, outvalid}, 32'h0);
        chk({tag, "_par_busy"}, {31'b0, busy},     32'h1);
        chk({tag, "_par_done"}, {31'b0, done},     32'h0);
        e = exp_perr;
`else
        e = 1'b0;
        if (par === 1'bx) e = exp_perr;
`endif
        drive(nxt);
        chk({tag, "_done"}, {31'b0, done},     32'h1);
        chk({tag, "_busy"}, {31'b0, busy},     32'h0);
        chk({tag, "_ov0"},  {28'b0, outvalid}, 32'h0);
        chk({tag, "_perr"}, {31'b0, perr},     {31'b0, e});
    endtask

    initial begin
        logic [14:0] long_pat;
        logic [7:0]  ovl_pat;

        rst  = 1'b0;
        in_s = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ov",   {28'b0, outvalid}, 32'h0);
        chk("rst_out",  {28'b0, out_s},    32'h0);
        chk("rst_busy", {31'b0, busy},     32'h0);
        chk("rst_done", {31'b0, done},     32'h0);
        chk("rst_perr", {31'b0, perr},     32'h0);
        @(negedge clk);
        rst = 1'b1;

        // basic packet: addr 10, len 3, payload 101
        drive(1'b1); drive(1'b1); drive(1'b0); drive(1'b1);
        chk("p1_hunt_busy", {31'b0, busy}, 32'h0);
        drive(1'b1);
        chk("p1_addr_busy", {31'b0, busy}, 32'h1);
        drive(1'b0);
        send_bits(32'b0011, 4);
        chk("p1_len_ov", {28'b0, outvalid}, 32'h0);
        pay_bit("p1_b0", 1'b1, 4'b0100);
        pay_bit("p1_b1", 1'b0, 4'b0100);
        pay_bit("p1_b2", 1'b1, 4'b0100);
        finish_pkt("p1", 1'b0, 1'b0, 1'b0);
        drive(1'b0);
        chk("p1_done_pulse", {31'b0, done}, 32'h0);

        // overlapping header 1101101: first match wins, 101 -> addr 10, len 1000
        send_bits(32'b1101101, 7);
        send_bits(32'b000, 3);
        ovl_pat = 8'b10110010;
        for (int i = 7; i >= 0; i--) pay_bit("ovl", ovl_pat[i], 4'b0100);
        finish_pkt("ovl", 1'b0, 1'b0, 1'b0);

        // zero length, followed at once by another header
        send_hdr(2'b01, 4'b0000);
        chk("z_len_ov", {28'b0, outvalid}, 32'h0);
        finish_pkt("z", 1'b0, 1'b0, 1'b1);
        send_bits(32'b101, 3);
        send_bits(32'b11, 2);
        send_bits(32'b0001, 4);
        pay_bit("z_next", 1'b1, 4'b1000);
        finish_pkt("z_next", 1'b1, 1'b0, 1'b1);

        // maximum length, then back-to-back header
        send_bits(32'b101, 3);
        send_bits(32'b00, 2);
        send_bits(32'b1111, 4);
        long_pat = 15'b110100110101101;
        for (int i = 14; i >= 0; i--) pay_bit("max", long_pat[i], 4'b0001);
        finish_pkt("max", 1'b1, 1'b0, 1'b1);
        send_bits(32'b101, 3);
        send_bits(32'b11, 2);
        send_bits(32'b0010, 4);
        pay_bit("b2b_b0", 1'b0, 4'b1000);
        pay_bit("b2b_b1", 1'b1, 4'b1000);
        finish_pkt("b2b", 1'b1, 1'b0, 1'b0);

        // reset during payload cycle 2
        send_hdr(2'b10, 4'b0101);
        pay_bit("rst_p0", 1'b1, 4'b0100);
        pay_bit("rst_p1", 1'b1, 4'b0100);
        rst = 1'b0;
        #1;
        chk("mid_rst_ov",   {28'b0, outvalid}, 32'h0);
        chk("mid_rst_out",  {28'b0, out_s},    32'h0);
        chk("mid_rst_busy", {31'b0, busy},     32'h0);
        @(negedge clk);
        #1;
        chk("mid_rst_done", {31'b0, done}, 32'h0);
        in_s = 1'b0;
        rst  = 1'b1;
        send_hdr(2'b01, 4'b0001);
        chk("post_rst_busy", {31'b0, busy}, 32'h1);
        pay_bit("post_rst", 1'b1, 4'b0010);
        chk("post_rst_done0", {31'b0, done}, 32'h0);
        finish_pkt("post_rst", 1'b1, 1'b0, 1'b0);

        // parity: payload 110 has even weight, so the correct parity bit is 0
        send_hdr(2'b01, 4'b0011);
        pay_bit("par_ok_b0", 1'b1, 4'b0010);
        pay_bit("par_ok_b1", 1'b1, 4'b0010);
        pay_bit("par_ok_b2", 1'b0, 4'b0010);
        finish_pkt("par_ok", 1'b0, 1'b0, 1'b0);
        send_hdr(2'b01, 4'b0011);
        pay_bit("par_bad_b0", 1'b1, 4'b0010);
        pay_bit("par_bad_b1", 1'b1, 4'b0010);
        pay_bit("par_bad_b2", 1'b0, 4'b0010);
        finish_pkt("par_bad", 1'b1, 1'b1, 1'b0);
        drive(1'b0);
        chk("par_perr_pulse", {31'b0, perr}, 32'h0);
        chk("par_done_pulse", {31'b0, done}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
